// File: rtl/mem_pkg.sv
// Shared types and helpers for the block-transfer memory responder.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        XFER,
        DONE
    } state_e;

    typedef enum logic {
        OP_RD,
        OP_WR
    } op_e;

    // Beat index width: clog2 of the block size, but never narrower than one bit.
    function automatic int beatw(input int blocksize);
        return (blocksize <= 2) ? 1 : $clog2(blocksize);
    endfunction

endpackage

// File: rtl/mem_block_responder_if.sv
// Cache-to-memory block refill/writeback bus; master = cache side, slave = memory side.
interface mem_block_responder_if #(
    parameter int AWIDTH    = 9,
    parameter int DWIDTH    = 32,
    parameter int BLOCKSIZE = 4
);
    import mem_pkg::*;

    localparam int BW = beatw(BLOCKSIZE);

    logic              rd_mem;
    logic              wr_mem;
    logic [AWIDTH-1:0] addr_mem;
    logic [DWIDTH-1:0] data_in;
    logic [DWIDTH-1:0] data_out;
    logic              ready_mem;
    logic [BW-1:0]     beat_idx;
    logic              busy;
    logic              err;

    modport master (
        output rd_mem, wr_mem, addr_mem, data_in,
        input  data_out, ready_mem, beat_idx, busy, err
    );

    modport slave (
        input  rd_mem, wr_mem, addr_mem, data_in,
        output data_out, ready_mem, beat_idx, busy, err
    );

endinterface

// File: rtl/mem_block_array.sv
// Single-port word array: synchronous write, registered read.
module mem_block_array #(
    parameter int AWIDTH = 9,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [AWIDTH-1:0] addr,
    input  logic [DWIDTH-1:0] wdata,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] mem [2**AWIDTH];

    // Storage itself is never cleared; only the read register has a reset value.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_block_responder.sv
// Memory-side block responder: moves one BLOCKSIZE-word block per request after LATENCY cycles.
// Optional MEM_STATS_EN adds saturating completed-read/write counters.
module mem_block_responder
    import mem_pkg::*;
#(
    parameter int AWIDTH    = 9,
    parameter int DWIDTH    = 32,
    parameter int BLOCKSIZE = 4,
    parameter int LATENCY   = 3
) (
    input  logic clk,
    input  logic reset,
    mem_block_responder_if.slave bus
`ifdef MEM_STATS_EN
    ,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
`endif
);

    localparam int                BW       = beatw(BLOCKSIZE);
    localparam logic [AWIDTH-1:0] OFF_MASK = AWIDTH'(BLOCKSIZE - 1);
    localparam logic [BW-1:0]     LAST     = BW'(BLOCKSIZE - 1);
    localparam logic [3:0]        LAT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    state_e            state;
    op_e               op;
    logic [AWIDTH-1:0] base;
    logic [BW-1:0]     beat;
    logic [3:0]        lat_cnt;
    logic              err_lock;
    logic              req_held;
    logic              arr_we;
    logic              arr_re;
    logic [AWIDTH-1:0] arr_addr;

    // Offset replaces the low address bits, so a block never carries into its neighbour.
    function automatic logic [AWIDTH-1:0] blk_addr(input logic [AWIDTH-1:0] b,
                                                   input logic [BW-1:0]     k);
        return b | (AWIDTH'(k) & OFF_MASK);
    endfunction

    assign req_held = (op == OP_RD) ? bus.rd_mem : bus.wr_mem;

    // Reads fetch the beat about to be presented; writes capture data_in while its
    // beat_idx is on the bus, i.e. one edge after that beat was presented.
    always_comb begin
        arr_we   = 1'b0;
        arr_re   = 1'b0;
        arr_addr = blk_addr(base, beat);
        if (op == OP_WR) begin
            arr_addr = blk_addr(base, bus.beat_idx);
            arr_we   = bus.ready_mem && bus.wr_mem;
        end else begin
            arr_re   = (state == XFER) && bus.rd_mem;
        end
    end

    mem_block_array #(
        .AWIDTH (AWIDTH),
        .DWIDTH (DWIDTH)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (arr_we),
        .re    (arr_re),
        .addr  (arr_addr),
        .wdata (bus.data_in),
        .rdata (bus.data_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            op            <= OP_RD;
            base          <= '0;
            beat          <= '0;
            lat_cnt       <= '0;
            err_lock      <= 1'b0;
            bus.ready_mem <= 1'b0;
            bus.beat_idx  <= '0;
            bus.busy      <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            bus.err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (err_lock) begin
                        if (!bus.rd_mem && !bus.wr_mem) begin
                            err_lock <= 1'b0;
                        end
                    end else if (bus.rd_mem && bus.wr_mem) begin
                        bus.err  <= 1'b1;
                        err_lock <= 1'b1;
                    end else if (bus.rd_mem || bus.wr_mem) begin
                        op       <= bus.wr_mem ? OP_WR : OP_RD;
                        base     <= bus.addr_mem & ~OFF_MASK;
                        beat     <= '0;
                        lat_cnt  <= LAT_INIT;
                        bus.busy <= 1'b1;
                        state    <= (LATENCY == 0) ? XFER : WAIT;
                    end
                end
                WAIT: begin
                    if (!req_held) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end else if (lat_cnt == 4'd0) begin
                        state <= XFER;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                XFER: begin
                    if (!req_held) begin
                        state         <= IDLE;
                        bus.ready_mem <= 1'b0;
                        bus.busy      <= 1'b0;
                    end else begin
                        bus.ready_mem <= 1'b1;
                        bus.beat_idx  <= beat;
                        beat          <= beat + BW'(1);
                        if (beat == LAST) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    bus.ready_mem <= 1'b0;
                    if (!bus.rd_mem && !bus.wr_mem) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_STATS_EN
    logic last_beat_done;

    // A request counts only if it is still held at the end of its final beat.
    assign last_beat_done = bus.ready_mem && (bus.beat_idx == LAST) && req_held;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (last_beat_done) begin
            if (op == OP_RD && rd_count != 16'hFFFF) begin
                rd_count <= rd_count + 16'd1;
            end
            if (op == OP_WR && wr_count != 16'hFFFF) begin
                wr_count <= wr_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_block_responder.sv
// Bench for mem_block_responder: table vectors, random transactions vs. a word-array model, corner sequences.
module tb_mem_block_responder;

    localparam int LAT = 3;
    localparam int BS  = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mem_block_responder_if #(.AWIDTH(9), .DWIDTH(32), .BLOCKSIZE(BS)) bus ();
    mem_block_responder_if #(.AWIDTH(9), .DWIDTH(32), .BLOCKSIZE(BS)) bus0 ();

`ifdef MEM_STATS_EN
    logic [15:0] rd_cnt, wr_cnt, rd_cnt0, wr_cnt0;
`endif

    mem_block_responder #(.AWIDTH(9), .DWIDTH(32), .BLOCKSIZE(BS), .LATENCY(LAT)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus)
`ifdef MEM_STATS_EN
        ,
        .rd_count (rd_cnt),
        .wr_count (wr_cnt)
`endif
    );

    mem_block_responder #(.AWIDTH(9), .DWIDTH(32), .BLOCKSIZE(BS), .LATENCY(0)) dut0 (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus0)
`ifdef MEM_STATS_EN
        ,
        .rd_count (rd_cnt0),
        .wr_count (wr_cnt0)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [512];
    int exp_rd = 0;
    int exp_wr = 0;

    typedef struct {
        int          op;       // 0 read, 1 write, 2 both high
        logic [8:0]  addr;
        int          hold;     // beats held to completion; >=BS full, <0 drop during latency
        logic [31:0] dpat;     // nonzero: write word b = dpat*(b+1)
        int          exp_ready;
        int          exp_err;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One request on the LATENCY=3 instance; every cycle is checked against the timing
    // rules and the array model, which is updated with the beats that were held.
    task automatic run_block(input int op, input logic [8:0] addr, input int hold,
                             input logic [31:0] dpat, output int nready, output int nerr);
        int          k_drop;
        int          b;
        logic [8:0]  base;
        logic [31:0] wd [BS];
        logic        exp_rdy;
        base   = addr & ~9'(BS - 1);
        k_drop = (op == 2) ? 2 : LAT + 1 + hold;
        for (int i = 0; i < BS; i++) wd[i] = (dpat != 0) ? dpat * 32'(i + 1) : $urandom;
        nready = 0;
        nerr   = 0;
        bus.rd_mem   = (op != 1);
        bus.wr_mem   = (op != 0);
        bus.addr_mem = addr;
        bus.data_in  = $urandom;
        for (int k = 0; k <= k_drop + 1; k++) begin
            @(posedge clk);
            @(negedge clk);
            exp_rdy = (op != 2) && (k >= LAT + 1) && (k <= LAT + BS) && (k <= k_drop);
            b = k - LAT - 1;
            chk("ready_mem", 32'(bus.ready_mem), 32'(exp_rdy));
            chk("busy", 32'(bus.busy), 32'((op != 2) && (k <= k_drop)));
            chk("err", 32'(bus.err), 32'((op == 2) && (k == 0)));
            if (bus.ready_mem) nready++;
            if (bus.err) nerr++;
            if (exp_rdy) begin
                chk("beat_idx", 32'(bus.beat_idx), 32'(b));
                if (op == 0) chk("data_out", bus.data_out, ref_mem[base | 9'(b)]);
                bus.data_in = wd[b];
            end else begin
                bus.data_in = $urandom;
            end
            if (k == k_drop) begin
                bus.rd_mem = 1'b0;
                bus.wr_mem = 1'b0;
            end
        end
        if (op == 1) begin
            for (int i = 0; i < BS; i++)
                if (i < k_drop - LAT - 1) ref_mem[base | 9'(i)] = wd[i];
        end
        if (op == 0 && hold >= BS) exp_rd++;
        if (op == 1 && hold >= BS) exp_wr++;
    endtask

    initial begin
        int nr, ne, op, hold;
        #200_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nr, ne, op, hold;
        reset = 1'b1;
        bus.rd_mem = 1'b0;  bus.wr_mem = 1'b0;  bus.addr_mem = '0;  bus.data_in = '0;
        bus0.rd_mem = 1'b0; bus0.wr_mem = 1'b0; bus0.addr_mem = '0; bus0.data_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset ready_mem", 32'(bus.ready_mem), 32'd0);
        chk("reset data_out", bus.data_out, 32'd0);
        chk("reset beat_idx", 32'(bus.beat_idx), 32'd0);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset err", 32'(bus.err), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Fill the whole array so every later read has a known model value.
        for (int a = 0; a < 512; a += BS) run_block(1, 9'(a), BS, 0, nr, ne);

        tbl[0]  = '{1, 9'h040, 4, 32'h0,  4, 0};
        tbl[1]  = '{0, 9'h042, 4, 32'h0,  4, 0};
        tbl[2]  = '{1, 9'h080, 4, 32'h11, 4, 0};
        tbl[3]  = '{0, 9'h080, 4, 32'h0,  4, 0};
        tbl[4]  = '{2, 9'h080, 0, 32'h0,  0, 1};
        tbl[5]  = '{0, 9'h083, 4, 32'h0,  4, 0};
        tbl[6]  = '{1, 9'h010, 2, 32'h55, 3, 0};
        tbl[7]  = '{0, 9'h011, 4, 32'h0,  4, 0};
        tbl[8]  = '{0, 9'h010, -2, 32'h0, 0, 0};
        tbl[9]  = '{0, 9'h020, 0, 32'h0,  1, 0};
        tbl[10] = '{1, 9'h1FD, 4, 32'h0,  4, 0};
        tbl[11] = '{0, 9'h1FF, 4, 32'h0,  4, 0};
        tbl[12] = '{0, 9'h040, 3, 32'h0,  4, 0};
        tbl[13] = '{1, 9'h030, -4, 32'h77, 0, 0};
        for (int i = 0; i < 14; i++) begin
            run_block(tbl[i].op, tbl[i].addr, tbl[i].hold, tbl[i].dpat, nr, ne);
            chk("vec ready count", 32'(nr), 32'(tbl[i].exp_ready));
            chk("vec err count", 32'(ne), 32'(tbl[i].exp_err));
        end

        for (int i = 0; i < 60; i++) begin
            op   = ($urandom_range(0, 9) == 0) ? 2 : int'($urandom_range(0, 1));
            hold = ($urandom_range(0, 1) == 1) ? BS : int'($urandom_range(0, 8)) - 4;
            run_block(op, 9'($urandom), hold, 0, nr, ne);
        end

        // LATENCY=0 instance: write block 0, then read it back with an unaligned address.
        bus0.wr_mem = 1'b1; bus0.addr_mem = 9'h002;
        for (int k = 0; k <= 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k >= 1 && k <= 4) bus0.data_in = 32'hC0 + 32'(k - 1);
            if (k == 5) bus0.wr_mem = 1'b0;
        end
        @(negedge clk);
        bus0.rd_mem = 1'b1; bus0.addr_mem = 9'h001;
        for (int k = 0; k <= 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("lat0 ready_mem", 32'(bus0.ready_mem), 32'(k >= 1 && k <= 4));
            if (k >= 1 && k <= 4) begin
                chk("lat0 beat_idx", 32'(bus0.beat_idx), 32'(k - 1));
                chk("lat0 data_out", bus0.data_out, 32'hC0 + 32'(k - 1));
            end
            if (k == 5) bus0.rd_mem = 1'b0;
        end
        @(negedge clk);
        chk("lat0 busy after drop", 32'(bus0.busy), 32'd0);

`ifdef MEM_STATS_EN
        chk("rd_count", 32'(rd_cnt), 32'(exp_rd));
        chk("wr_count", 32'(wr_cnt), 32'(exp_wr));
        chk("lat0 rd_count", 32'(rd_cnt0), 32'd1);
        chk("lat0 wr_count", 32'(wr_cnt0), 32'd1);
`endif

        // Make sure data_out holds a nonzero word before resetting mid-request.
        ref_mem[9'h044] = 32'hDEAD_BEEF;
        run_block(1, 9'h044, BS, 32'hDEAD_BEEF, nr, ne);
        run_block(0, 9'h044, BS, 0, nr, ne);
        bus.rd_mem = 1'b1; bus.addr_mem = 9'h044;
        @(posedge clk);
        @(negedge clk);
        chk("pre-reset busy", 32'(bus.busy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("wait-reset ready_mem", 32'(bus.ready_mem), 32'd0);
        chk("wait-reset data_out", bus.data_out, 32'd0);
        chk("wait-reset beat_idx", 32'(bus.beat_idx), 32'd0);
        chk("wait-reset busy", 32'(bus.busy), 32'd0);
        chk("wait-reset err", 32'(bus.err), 32'd0);
`ifdef MEM_STATS_EN
        chk("reset rd_count", 32'(rd_cnt), 32'd0);
        chk("reset wr_count", 32'(wr_cnt), 32'd0);
`endif
        reset = 1'b0;
        bus.rd_mem = 1'b0;
        @(negedge clk);
        run_block(0, 9'h044, BS, 0, nr, ne);
        chk("post-reset ready count", 32'(nr), 32'(BS));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
